// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; used for both the request tag list and
// the prefetch instruction queue.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot this cycle, so a full queue can still accept a push.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order reads,
// buffers returned words and drops stale responses after a redirect.
module fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_t       state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic [CNT_W-1:0]   outstanding, outstanding_next;
  logic [CNT_W-1:0]   drop_cnt, drop_next;
  logic [CNT_W-1:0]   tag_count, q_count;
  logic [CNT_W:0]     credit_used;
  logic [ADDR_W-1:0]  tag_addr;
  logic [ENTRY_W-1:0] q_head;
  logic               tag_full, tag_empty, q_full, q_empty;
  logic               req_fire, rsp_fire;
  logic               q_push, q_pop, q_flush;

  // Requests in flight plus buffered words may never exceed the queue depth,
  // so every response is guaranteed a slot.
  assign credit_used    = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = (state == RUN) && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && !tag_empty;

  assign if_valid = !q_empty;
  assign q_pop    = !q_empty && if_ready;
  assign if_pc    = q_empty ? '0 : q_head[ENTRY_W-1 -: ADDR_W];
  assign if_instr = q_empty ? NOP_INSTR : q_head[INSTR_W-1:0];

  fetch_queue #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req_fire),
    .pop   (rsp_fire),
    .flush (1'b0),
    .wdata (pc),
    .rdata (tag_addr),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  fetch_queue #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_prefetch_q (
    .clock (clock),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .wdata ({tag_addr, imem_rsp_data}),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    drop_next        = drop_cnt;
    q_push           = 1'b0;
    q_flush          = 1'b0;
    unique case (state)
      IDLE: state_next = RUN;
      RUN: begin
        if (req_fire) pc_next = pc + ADDR_W'(PC_STEP);
        q_push = rsp_fire;
      end
      FLUSH: begin
        if (rsp_fire) begin
          drop_next = drop_cnt - CNT_W'(1);
          if (drop_cnt == CNT_W'(1)) state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
    // Outside FLUSH every request still in flight becomes stale; inside FLUSH
    // they already are, so the running drop count carries over.
    if (redirect_valid) begin
      pc_next = redirect_pc & ~ADDR_W'(3);
      q_push  = 1'b0;
      q_flush = 1'b1;
      if (state != FLUSH) drop_next = outstanding_next;
      state_next = (drop_next != '0) ? FLUSH : RUN;
    end
  end

  assert property (@(posedge clock) disable iff (reset) imem_rsp_valid |-> (outstanding != '0));
  assert property (@(posedge clock) disable iff (reset) outstanding == tag_count);
  assert property (@(posedge clock) disable iff (reset) !(req_fire && tag_full));
  assert property (@(posedge clock) disable iff (reset) !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: pipelined memory model plus an address/instruction
// stream reference model, with directed scenarios followed by random traffic.
module tb_fetch_unit;
  import cpu_fetch_pkg::*;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;

  always #5 clock = ~clock;

  fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  typedef struct packed {logic [31:0] addr; logic stale;} inflight_t;
  typedef struct packed {logic [31:0] addr; int due;} memreq_t;

  int checks = 0;
  int errors = 0;

  inflight_t   inflight[$];
  logic [31:0] deliv[$];
  memreq_t     memq[$];
  logic [31:0] model_pc;
  bit          idle;
  int          cyc;
  int          mem_lat, ready_pct, ifready_pct;
  int          first_valid_cyc;
  logic [31:0] dut_req_log[$];
  logic [31:0] dut_req_cyc[$];
  logic [31:0] dut_del_log[$];
  logic [31:0] dut_ins_log[$];

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h012A_4020;
    if (a == 32'h4) return 32'h012A_4023;
    return {a[29:0], 2'b11} ^ 32'h3C00_0000;
  endfunction

  function automatic logic [31:0] logAt(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic bit anyStale();
    foreach (inflight[k]) if (inflight[k].stale) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic doReset();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    inflight.delete(); deliv.delete(); memq.delete();
    dut_req_log.delete(); dut_req_cyc.delete(); dut_del_log.delete(); dut_ins_log.delete();
    model_pc = RESET_PC;
    idle = 1'b1;
    cyc = 0;
    first_valid_cyc = -1;
  endtask

  // One clock cycle: called just after a falling edge, returns after the next one.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc);
    bit exp_req, exp_ifv, req_fire, rsp_fire, pop;
    logic [31:0] exp_pc, exp_instr;
    inflight_t f;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    if_ready       = ($urandom_range(99) < ifready_pct);
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp_fire       = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp_fire;
    imem_rsp_data  = rsp_fire ? memword(memq[0].addr) : $urandom;
    #1;
    exp_req   = !idle && !anyStale() && (inflight.size() + deliv.size() < DEPTH);
    exp_ifv   = (deliv.size() > 0);
    exp_pc    = exp_ifv ? deliv[0] : 32'h0;
    exp_instr = exp_ifv ? memword(deliv[0]) : NOP_INSTR;
    checkOutput("req_valid", 64'(imem_req_valid), 64'(exp_req));
    checkOutput("req_addr",  64'(imem_req_addr),  64'(model_pc));
    checkOutput("if_valid",  64'(if_valid),       64'(exp_ifv));
    checkOutput("if_pc",     64'(if_pc),          64'(exp_pc));
    checkOutput("if_instr",  64'(if_instr),       64'(exp_instr));
    if (imem_req_valid && imem_req_ready) begin
      dut_req_log.push_back(imem_req_addr);
      dut_req_cyc.push_back(32'(cyc));
    end
    if (if_valid && if_ready) begin
      dut_del_log.push_back(if_pc);
      dut_ins_log.push_back(if_instr);
    end
    if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    req_fire = exp_req && imem_req_ready;
    pop      = exp_ifv && if_ready;
    @(posedge clock);
    if (pop) void'(deliv.pop_front());
    if (rsp_fire && inflight.size() > 0) begin
      void'(memq.pop_front());
      f = inflight.pop_front();
      if (!f.stale && !redir) deliv.push_back(f.addr);
    end
    if (req_fire) begin
      inflight.push_back('{addr: model_pc, stale: 1'b0});
      memq.push_back('{addr: model_pc, due: cyc + mem_lat});
      model_pc = model_pc + 32'd4;
    end
    if (redir) begin
      foreach (inflight[k]) inflight[k].stale = 1'b1;
      deliv.delete();
      model_pc = rpc & ~32'd3;
    end
    idle = 1'b0;
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    bit r;
    mem_lat = 1; ready_pct = 100; ifready_pct = 100;

    // Reset release, 1-cycle memory, decode always ready.
    doReset();
    repeat (8) applyStimulus(1'b0, $urandom);
    checkOutput("first_valid_cycle", 64'(first_valid_cyc), 64'd3);
    checkOutput("p1_req0", 64'(logAt(dut_req_log, 0)), 64'h0);
    checkOutput("p1_req1", 64'(logAt(dut_req_log, 1)), 64'h4);
    checkOutput("p1_req2", 64'(logAt(dut_req_log, 2)), 64'h8);
    checkOutput("p1_reqcyc0", 64'(logAt(dut_req_cyc, 0)), 64'd1);
    checkOutput("p1_reqcyc2", 64'(logAt(dut_req_cyc, 2)), 64'd3);
    checkOutput("p1_ins0", 64'(logAt(dut_ins_log, 0)), 64'h012A_4020);
    checkOutput("p1_ins1", 64'(logAt(dut_ins_log, 1)), 64'h012A_4023);
    checkOutput("p1_pc1",  64'(logAt(dut_del_log, 1)), 64'h4);

    // Decode stalled: credit caps requests at DEPTH.
    doReset();
    ifready_pct = 0;
    repeat (11) applyStimulus(1'b0, $urandom);
    checkOutput("p2_req_count", 64'(dut_req_log.size()), 64'd4);
    checkOutput("p2_req_valid_low", 64'(imem_req_valid), 64'd0);
    ifready_pct = 100;
    repeat (10) applyStimulus(1'b0, $urandom);
    for (int i = 0; i < 4; i++)
      checkOutput("p2_order", 64'(logAt(dut_del_log, i)), 64'(4 * i));

    // Redirect with three requests in flight on a 3-cycle memory.
    doReset();
    mem_lat = 3;
    repeat (3) applyStimulus(1'b0, $urandom);
    applyStimulus(1'b1, 32'h0000_0103);
    repeat (12) applyStimulus(1'b0, $urandom);
    checkOutput("p3_req_after_redirect", 64'(logAt(dut_req_log, 3)), 64'h100);
    checkOutput("p3_first_delivered", 64'(logAt(dut_del_log, 0)), 64'h100);

    // Redirect coinciding with a decode pop and a response.
    doReset();
    mem_lat = 1;
    repeat (3) applyStimulus(1'b0, $urandom);
    applyStimulus(1'b1, 32'h0000_0100);
    repeat (8) applyStimulus(1'b0, $urandom);
    checkOutput("p4_popped", 64'(logAt(dut_del_log, 0)), 64'h0);
    checkOutput("p4_next",   64'(logAt(dut_del_log, 1)), 64'h100);

    // Redirect in IDLE near the top of memory; PC wraps.
    doReset();
    applyStimulus(1'b1, 32'hFFFF_FFFB);
    repeat (5) applyStimulus(1'b0, $urandom);
    checkOutput("p5_wrap0", 64'(logAt(dut_req_log, 0)), 64'hFFFF_FFF8);
    checkOutput("p5_wrap1", 64'(logAt(dut_req_log, 1)), 64'hFFFF_FFFC);
    checkOutput("p5_wrap2", 64'(logAt(dut_req_log, 2)), 64'h0000_0000);

    // Asynchronous reset between clock edges mid-burst.
    doReset();
    mem_lat = 2;
    repeat (6) applyStimulus(1'b0, $urandom);
    #2 reset = 1'b1;
    #1;
    checkOutput("ar_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("ar_req_addr",  64'(imem_req_addr),  64'(RESET_PC));
    checkOutput("ar_if_valid",  64'(if_valid),       64'd0);
    checkOutput("ar_if_instr",  64'(if_instr),       64'(NOP_INSTR));
    checkOutput("ar_if_pc",     64'(if_pc),          64'd0);
    doReset();
    repeat (4) applyStimulus(1'b0, $urandom);
    checkOutput("ar_first_req_cyc",  64'(logAt(dut_req_cyc, 0)), 64'd1);
    checkOutput("ar_first_req_addr", 64'(logAt(dut_req_log, 0)), 64'(RESET_PC));

    // Random traffic with occasional redirects.
    doReset();
    for (int blk = 0; blk < 6; blk++) begin
      mem_lat     = $urandom_range(1, 4);
      ready_pct   = $urandom_range(40, 100);
      ifready_pct = $urandom_range(30, 100);
      for (int i = 0; i < 200; i++) begin
        r = ($urandom_range(99) < 4);
        applyStimulus(r, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 32-bit MIPS core, sitting directly upstream of decode. It owns the program counter and issues in-order word reads to instruction memory through a ready/valid request channel. It buffers returned instructions in a small prefetch queue and hands them to decode with a valid/ready handshake. Branch/jump redirects from later stages flush the queue and discard stale in-flight responses.

Parameters:
ADDR_W, 32, byte-address width of PC and memory address
DEPTH, 4, prefetch queue entries; also the cap on in-flight requests plus queued entries
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
imem_req_valid  out  1  read request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  ADDR_W  byte address, word aligned (bits [1:0] = 0)
imem_rsp_valid  in  1  read data valid; responses return strictly in request order
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  ADDR_W  new PC; bits [1:0] are ignored and forced to 0
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts instruction
if_instr  out  32  instruction word
if_pc  out  ADDR_W  byte address of if_instr

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, outstanding=0, drop_cnt=0, queue empty; imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
- FSM states:
  - IDLE: entered on reset. Moves to RUN on the first clock after reset deasserts. No requests are issued in IDLE.
  - RUN: imem_req_valid=1 when outstanding+count < DEPTH. On a request handshake, pc += 4 with a 32-bit wrap (FFFF_FFFC -> 0000_0000) and outstanding++.
  - FLUSH: no requests are issued. Each response decrements drop_cnt and outstanding, and the data is discarded. Moves to RUN on the edge where drop_cnt reaches 0.
- Response in RUN: push {pc_of_req, data} into the queue and decrement outstanding. The credit rule guarantees the queue never overflows. A response arriving with no outstanding request is an error; the design asserts on it in simulation.
- Each outstanding request carries its address through a small in-order tag FIFO, depth DEPTH. if_pc is sourced from this FIFO.
- Decode side: if_valid = queue not empty; if_instr and if_pc come from the queue head. Pop on if_valid && if_ready. A push and a pop in the same cycle are both legal when the queue is full or empty.
- Latency: with single-cycle memory and if_ready=1, the first request is issued in cycle 1 after reset deasserts. if_valid rises in cycle 3. Steady-state throughput is 1 instruction per cycle.
- Redirect, taking priority over everything except reset:
  - pc <= {redirect_pc[31:2],2'b00}; the queue is flushed.
  - drop_cnt <= outstanding, counting any request handshaking in the same cycle and excluding any response arriving in the same cycle, which is itself dropped.
  - Next state is FLUSH if that drop_cnt is nonzero, otherwise RUN.
  - A decode pop in the same cycle completes; that instruction is delivered.
  - A redirect during FLUSH reloads pc and keeps the current drop_cnt. All in-flight requests are already stale.
  - A redirect in IDLE loads pc, and the block enters RUN normally.
- Reset mid-operation returns the block to IDLE immediately. Responses to pre-reset requests are the memory's responsibility; the memory is reset with the core.
- imem_req_addr is held stable while imem_req_valid=1 and imem_req_ready=0.

Decomposition:
- cpu_fetch_pkg:
  - fetch_state_t enum {IDLE, RUN, FLUSH}
  - INSTR_W=32
  - PC_STEP=4
  - NOP_INSTR=32'h0000_0000
- Sub-module fetch_queue: a parameterised synchronous FIFO with width and depth parameters, async active-high reset, push/pop/flush, and full/empty/count outputs. It is instantiated twice: once for the tag FIFO and once for the prefetch queue.

Test Plan:
- Reset release with 1-cycle memory holding 012A4020 at 0x0 and 012A4023 at 0x4, if_ready=1 -> requests 0x0, 0x4, 0x8… in consecutive cycles; first if_valid in cycle 3 with if_instr=012A4020, if_pc=0; next cycle 012A4023, if_pc=4.
- if_ready=0 for 10 cycles -> exactly 4 requests issued, then imem_req_valid=0; after if_ready rises, instructions resume in order 0x0 to 0xC with no loss or duplication.
- 3-cycle memory latency with 3 requests in flight, then redirect_pc=0x103 -> queue empties the next cycle; 3 responses are dropped; the next request has address 0x100; the first delivered if_pc is 0x100.
- Redirect in the same cycle as a decode pop and a response -> the popped instruction is delivered; the response is dropped; no if_valid until the 0x100 data returns.
- pc=FFFF_FFF8 with back-to-back fetch -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset asynchronously mid-burst, between clock edges -> all outputs return to their reset values at once; after deassert, the first request is to RESET_PC in cycle 1.
